// File: rtl/structures.sv
// -----------------------------------------------------------------------------
// structures : shared decode/execute types.
//   instr_structure : decoded control word handed from decode to execute.
//   ALU_FUNC_*      : ALU function codes. ALU_FUNC_NOP is kept distinct from
//                     every real code so execute takes its hold branch.
//   OPB_*           : operand-B source select codes.
//   nop_instr()     : all-zero control word carrying ALU_FUNC_NOP.
// -----------------------------------------------------------------------------
package structures;

   localparam logic [3:0] ALU_FUNC_ADD  = 4'd0;
   localparam logic [3:0] ALU_FUNC_SUB  = 4'd1;
   localparam logic [3:0] ALU_FUNC_AND  = 4'd2;
   localparam logic [3:0] ALU_FUNC_OR   = 4'd3;
   localparam logic [3:0] ALU_FUNC_XOR  = 4'd4;
   localparam logic [3:0] ALU_FUNC_SLL  = 4'd5;
   localparam logic [3:0] ALU_FUNC_SRL  = 4'd6;
   localparam logic [3:0] ALU_FUNC_SRA  = 4'd7;
   localparam logic [3:0] ALU_FUNC_SLT  = 4'd8;
   localparam logic [3:0] ALU_FUNC_SLTU = 4'd9;
   localparam logic [3:0] ALU_FUNC_NOP  = 4'hF;

   localparam logic [1:0] OPB_REG = 2'd0;
   localparam logic [1:0] OPB_IMM = 2'd1;
   localparam logic [1:0] OPB_PC  = 2'd2;

   typedef struct packed {
      logic [3:0] alu_func;
      logic [1:0] opb_sel;
      logic       word_op;
   } dec_structure;

   typedef struct packed {
      dec_structure f_dec;
      logic [4:0]   rd;
      logic         reg_wr;
   } instr_structure;

   function automatic instr_structure nop_instr();
      instr_structure i;
      i = '0;
      i.f_dec.alu_func = ALU_FUNC_NOP;
      return i;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter : combinational rotating-priority picker.
//   valid [NREQ] : candidate requests
//   ptr   [ID_W] : highest-priority index this cycle
//   grant [NREQ] : one-hot pick (zero when nothing is valid)
//   win   [ID_W] : index of the pick (zero when nothing is valid)
// -----------------------------------------------------------------------------
module rr_arbiter #(
   parameter int NREQ = 2,
   parameter int ID_W = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] valid,
   input  logic [ID_W-1:0] ptr,
   output logic [NREQ-1:0] grant,
   output logic [ID_W-1:0] win
);

   int idx;

   // Walk from the lowest-priority slot towards ptr; the last hit is the
   // closest one to ptr, so no early-exit flag is needed.
   always_comb begin
      grant = '0;
      win   = '0;
      idx   = 0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = (int'(ptr) + k) % NREQ;
         if (valid[idx]) begin
            grant      = '0;
            grant[idx] = 1'b1;
            win        = ID_W'(idx);
         end
      end
   end

endmodule

// File: rtl/alu_issue_arbiter.sv
// -----------------------------------------------------------------------------
// alu_issue_arbiter : shares the registered execute ALU between NREQ
// requesters with round-robin arbitration and returns results in order.
//   clk, reset (async, active low)
//   req_valid/req_ready/req_cont/req_op1/req_op2/req_tag : request channels
//   alu_op_oCont/alu_op1/alu_op2 : operation into execute (no-op when idle)
//   exe_result/exe_zero          : execute result registers
//   flush                        : drop the held response, block issue
//   rsp_valid/rsp_ready/rsp_id/rsp_tag/rsp_result/rsp_zero : response
// -----------------------------------------------------------------------------
module alu_issue_arbiter
   import structures::*;
#(
   parameter int NREQ  = 2,
   parameter int TAG_W = 4,
   parameter int ID_W  = $clog2(NREQ)
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [NREQ-1:0]                 req_valid,
   output logic [NREQ-1:0]                 req_ready,
   input  instr_structure [NREQ-1:0]       req_cont,
   input  logic [NREQ-1:0][31:0]           req_op1,
   input  logic [NREQ-1:0][31:0]           req_op2,
   input  logic [NREQ-1:0][TAG_W-1:0]      req_tag,
   output instr_structure                  alu_op_oCont,
   output logic [31:0]                     alu_op1,
   output logic [31:0]                     alu_op2,
   input  logic [63:0]                     exe_result,
   input  logic                            exe_zero,
   input  logic                            flush,
   output logic                            rsp_valid,
   input  logic                            rsp_ready,
   output logic [ID_W-1:0]                 rsp_id,
   output logic [TAG_W-1:0]                rsp_tag,
   output logic [63:0]                     rsp_result,
   output logic                            rsp_zero
);

   logic [ID_W-1:0] ptr;
   logic [NREQ-1:0] arb_valid;
   logic [NREQ-1:0] grant;
   logic [ID_W-1:0] win;
   logic            slot_free;
   logic            any_grant;

   // reset is in the slot term so nothing is granted while reset is held,
   // even if requesters keep their valids up.
   assign slot_free = reset && !flush && (!rsp_valid || rsp_ready);
   assign arb_valid = slot_free ? req_valid : '0;

   rr_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) u_arb (
      .valid (arb_valid),
      .ptr   (ptr),
      .grant (grant),
      .win   (win)
   );

   assign any_grant = |grant;
   assign req_ready = grant;

   always_comb begin
      alu_op_oCont = nop_instr();
      alu_op1      = '0;
      alu_op2      = '0;
      if (any_grant) begin
         alu_op_oCont = req_cont[win];
         alu_op1      = req_op1[win];
         alu_op2      = req_op2[win];
      end
   end

   // execute holds its result on the no-op, so these stay stable while the
   // response is back-pressured.
   assign rsp_result = exe_result;
   assign rsp_zero   = exe_zero;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr       <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_tag   <= '0;
      end else begin
         if (any_grant)
            ptr <= (win == ID_W'(NREQ - 1)) ? '0 : win + ID_W'(1);

         if (flush) begin
            rsp_valid <= 1'b0;
         end else if (any_grant) begin
            rsp_valid <= 1'b1;
            rsp_id    <= win;
            rsp_tag   <= req_tag[win];
         end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu_issue_arbiter.sv
module tb_alu_issue_arbiter;
   import structures::*;

   localparam int NREQ  = 2;
   localparam int TAG_W = 4;
   localparam int ID_W  = 1;

   logic                       clk = 1'b0;
   logic                       rst_n = 1'b0;
   logic [NREQ-1:0]            req_valid;
   logic [NREQ-1:0]            req_ready;
   instr_structure [NREQ-1:0]  req_cont;
   logic [NREQ-1:0][31:0]      req_op1, req_op2;
   logic [NREQ-1:0][TAG_W-1:0] req_tag;
   instr_structure             alu_op_oCont;
   logic [31:0]                alu_op1, alu_op2;
   logic [63:0]                exe_result;
   logic                       exe_zero;
   logic                       flush, rsp_valid, rsp_ready;
   logic [ID_W-1:0]            rsp_id;
   logic [TAG_W-1:0]           rsp_tag;
   logic [63:0]                rsp_result;
   logic                       rsp_zero;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_issue_arbiter #(.NREQ(NREQ), .TAG_W(TAG_W), .ID_W(ID_W)) dut (
      .clk(clk), .reset(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_cont(req_cont),
      .req_op1(req_op1), .req_op2(req_op2), .req_tag(req_tag),
      .alu_op_oCont(alu_op_oCont), .alu_op1(alu_op1), .alu_op2(alu_op2),
      .exe_result(exe_result), .exe_zero(exe_zero), .flush(flush),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_tag(rsp_tag), .rsp_result(rsp_result), .rsp_zero(rsp_zero)
   );

   function automatic logic [63:0] alu_fn(logic [3:0] f, logic [31:0] a, logic [31:0] b);
      case (f)
         ALU_FUNC_ADD: return {32'd0, a + b};
         ALU_FUNC_SUB: return {32'd0, a - b};
         ALU_FUNC_AND: return {32'd0, a & b};
         ALU_FUNC_OR:  return {32'd0, a | b};
         ALU_FUNC_XOR: return {32'd0, a ^ b};
         default:      return 64'd0;
      endcase
   endfunction

   // Stand-in for the registered execute stage: holds on the no-op.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exe_result <= '0;
         exe_zero   <= 1'b1;
      end else if (alu_op_oCont.f_dec.alu_func != ALU_FUNC_NOP) begin
         exe_result <= alu_fn(alu_op_oCont.f_dec.alu_func, alu_op1, alu_op2);
         exe_zero   <= (alu_fn(alu_op_oCont.f_dec.alu_func, alu_op1, alu_op2) == 64'd0);
      end
   end

   // Requester rule: a valid, ungranted request must not change.
   logic [NREQ-1:0]            pend;
   instr_structure [NREQ-1:0]  p_cont;
   logic [NREQ-1:0][31:0]      p_op1, p_op2;
   logic [NREQ-1:0][TAG_W-1:0] p_tag;
   always @(negedge clk) begin
      if (!rst_n) begin
         pend <= '0;
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            if (pend[i]) begin
               checks++;
               if (!req_valid[i] || req_cont[i] !== p_cont[i] || req_op1[i] !== p_op1[i] ||
                   req_op2[i] !== p_op2[i] || req_tag[i] !== p_tag[i]) begin
                  errors++;
                  $display("FAIL hold_rule: requester %0d changed before grant (valid=%b)", i, req_valid[i]);
               end
            end
         end
         pend   <= req_valid & ~req_ready;
         p_cont <= req_cont;
         p_op1  <= req_op1;
         p_op2  <= req_op2;
         p_tag  <= req_tag;
      end
   end

   // Reference model: priority pointer, one-deep response slot, result.
   int               m_ptr, m_id, last_g;
   bit               m_valid, m_zero;
   logic [TAG_W-1:0] m_tag;
   logic [63:0]      m_res;

   function automatic int pick();
      if (!rst_n || flush || (m_valid && !rsp_ready)) return -1;
      for (int k = 0; k < NREQ; k++)
         if (req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
      return -1;
   endfunction

   function automatic logic [NREQ-1:0] onehot(int g);
      logic [NREQ-1:0] v;
      v = '0;
      if (g >= 0) v[g] = 1'b1;
      return v;
   endfunction

   task automatic model_reset();
      m_ptr = 0; m_id = 0; m_valid = 0; m_tag = '0; m_res = '0; m_zero = 1; last_g = -1;
   endtask

   // Evaluate the cycle in the model, cross the edge, land 1 time unit after it.
   task automatic step();
      int g;
      g = pick();
      last_g = g;
      if (g >= 0) begin
         m_res  = alu_fn(req_cont[g].f_dec.alu_func, req_op1[g], req_op2[g]);
         m_zero = (m_res == 64'd0);
      end
      if (flush) m_valid = 0;
      else if (g >= 0) begin m_valid = 1; m_id = g; m_tag = req_tag[g]; end
      else if (rsp_ready) m_valid = 0;
      if (g >= 0) m_ptr = (g + 1) % NREQ;
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(int i, logic [3:0] f, logic [31:0] a, logic [31:0] b, logic [TAG_W-1:0] t);
      req_valid[i] = 1'b1;
      req_cont[i]  = '0;
      req_cont[i].f_dec.alu_func = f;
      req_op1[i] = a;
      req_op2[i] = b;
      req_tag[i] = t;
   endtask

   task automatic do_reset();
      rst_n = 0;
      req_valid = '0; req_cont = '0; req_op1 = '0; req_op2 = '0; req_tag = '0;
      flush = 0; rsp_ready = 1;
      @(posedge clk);
      #1;
      rst_n = 1;
      model_reset();
   endtask

   task automatic test_reset();
      req_valid = '0; req_cont = '0; req_op1 = '0; req_op2 = '0; req_tag = '0;
      flush = 0; rsp_ready = 1; rst_n = 0;
      @(posedge clk); #1;
      set_req(0, ALU_FUNC_ADD, 1, 2, 1);
      set_req(1, ALU_FUNC_ADD, 3, 4, 2);
      #1;
      checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b want 00", req_ready); end
      checks++; if (alu_op_oCont !== nop_instr() || alu_op1 !== 0 || alu_op2 !== 0) begin errors++; $display("FAIL reset_nop: func=%h op1=%h op2=%h", alu_op_oCont.f_dec.alu_func, alu_op1, alu_op2); end
      checks++; if (rsp_valid !== 1'b0 || rsp_id !== '0 || rsp_tag !== '0) begin errors++; $display("FAIL reset_rsp: valid=%b id=%0d tag=%0d want 0/0/0", rsp_valid, rsp_id, rsp_tag); end
      @(posedge clk); #1;
      rst_n = 1;
      model_reset();
      #1;
      checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL reset_first_grant: got %b want 01", req_ready); end
      step();
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== 64'd3) begin errors++; $display("FAIL reset_first_rsp: valid=%b id=%0d res=%0d want 1/0/3", rsp_valid, rsp_id, rsp_result); end
   endtask

   task automatic test_single_add();
      do_reset();
      set_req(0, ALU_FUNC_ADD, 5, 7, 3);
      #1;
      checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL add_grant: got %b want 01", req_ready); end
      checks++; if (alu_op_oCont.f_dec.alu_func !== ALU_FUNC_ADD || alu_op1 !== 32'd5 || alu_op2 !== 32'd7) begin errors++; $display("FAIL add_alu: func=%h op1=%0d op2=%0d want 0/5/7", alu_op_oCont.f_dec.alu_func, alu_op1, alu_op2); end
      step();
      req_valid = '0;
      #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_tag !== 4'd3) begin errors++; $display("FAIL add_rsp: valid=%b id=%0d tag=%0d want 1/0/3", rsp_valid, rsp_id, rsp_tag); end
      checks++; if (rsp_result !== 64'd12 || rsp_zero !== 1'b0) begin errors++; $display("FAIL add_result: got %0d zero=%b want 12/0", rsp_result, rsp_zero); end
      step();
      #1;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL add_retire: rsp_valid=%b want 0", rsp_valid); end
   endtask

   task automatic test_round_robin();
      logic [TAG_W-1:0] t;
      do_reset();
      set_req(0, ALU_FUNC_ADD, 10, 1, 1);
      set_req(1, ALU_FUNC_ADD, 20, 1, 2);
      for (int c = 0; c < 6; c++) begin
         #1;
         checks++; if (req_ready !== onehot(c % 2)) begin errors++; $display("FAIL rr_grant[%0d]: got %b want %b", c, req_ready, onehot(c % 2)); end
         t = req_tag[c % 2];
         step();
         checks++; if (rsp_valid !== 1'b1 || rsp_tag !== t || rsp_id !== ID_W'(c % 2) || rsp_result !== m_res) begin errors++; $display("FAIL rr_rsp[%0d]: valid=%b id=%0d tag=%0d res=%0d want 1/%0d/%0d/%0d", c, rsp_valid, rsp_id, rsp_tag, rsp_result, c % 2, t, m_res); end
         set_req(c % 2, ALU_FUNC_ADD, 32'(c * 3), 32'd2, TAG_W'(c + 3));
      end
   endtask

   task automatic test_back_pressure();
      do_reset();
      set_req(0, ALU_FUNC_SUB, 9, 4, 5);
      #1;
      checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL bp_issue: got %b want 01", req_ready); end
      step();
      set_req(0, ALU_FUNC_ADD, 1, 1, 6);
      set_req(1, ALU_FUNC_ADD, 2, 2, 7);
      rsp_ready = 0;
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++; if (req_ready !== 2'b00 || alu_op_oCont.f_dec.alu_func !== ALU_FUNC_NOP || alu_op1 !== 0) begin errors++; $display("FAIL bp_hold[%0d]: ready=%b func=%h op1=%0d want 00/f/0", c, req_ready, alu_op_oCont.f_dec.alu_func, alu_op1); end
         checks++; if (rsp_valid !== 1'b1 || rsp_result !== 64'd5 || rsp_tag !== 4'd5) begin errors++; $display("FAIL bp_rsp[%0d]: valid=%b res=%0d tag=%0d want 1/5/5", c, rsp_valid, rsp_result, rsp_tag); end
         step();
      end
      rsp_ready = 1;
      #1;
      checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL bp_release: got %b want 10", req_ready); end
      step();
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_tag !== 4'd7 || rsp_result !== 64'd4) begin errors++; $display("FAIL bp_next: valid=%b id=%0d tag=%0d res=%0d want 1/1/7/4", rsp_valid, rsp_id, rsp_tag, rsp_result); end
   endtask

   task automatic test_flush();
      do_reset();
      set_req(1, ALU_FUNC_ADD, 3, 3, 2);
      #1;
      checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL flush_issue: got %b want 10", req_ready); end
      step();
      rsp_ready = 0;
      #1;
      step();
      checks++; if (rsp_valid !== 1'b1 || rsp_tag !== 4'd2) begin errors++; $display("FAIL flush_held: valid=%b tag=%0d want 1/2", rsp_valid, rsp_tag); end
      set_req(0, ALU_FUNC_ADD, 1, 2, 9);
      rsp_ready = 1;
      flush = 1;
      #1;
      checks++; if (req_ready !== 2'b00 || alu_op_oCont.f_dec.alu_func !== ALU_FUNC_NOP) begin errors++; $display("FAIL flush_block: ready=%b func=%h want 00/f", req_ready, alu_op_oCont.f_dec.alu_func); end
      step();
      flush = 0;
      #1;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL flush_clear: rsp_valid=%b want 0", rsp_valid); end
      checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL flush_ptr: got %b want 01", req_ready); end
      step();
   endtask

   task automatic test_reset_mid();
      do_reset();
      set_req(0, ALU_FUNC_ADD, 8, 8, 4);
      #1;
      step();
      rsp_ready = 0;
      set_req(0, ALU_FUNC_ADD, 2, 2, 12);
      set_req(1, ALU_FUNC_ADD, 1, 1, 11);
      #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_result !== 64'd16) begin errors++; $display("FAIL rmid_held: valid=%b res=%0d want 1/16", rsp_valid, rsp_result); end
      #1;
      rst_n = 0;
      #1;
      model_reset();
      checks++; if (rsp_valid !== 1'b0 || req_ready !== 2'b00 || alu_op_oCont !== nop_instr()) begin errors++; $display("FAIL rmid_async: valid=%b ready=%b func=%h want 0/00/f", rsp_valid, req_ready, alu_op_oCont.f_dec.alu_func); end
      @(posedge clk); #1;
      rst_n = 1;
      rsp_ready = 1;
      #1;
      checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rmid_ptr: got %b want 01", req_ready); end
      step();
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_tag !== 4'd12) begin errors++; $display("FAIL rmid_first: valid=%b id=%0d tag=%0d want 1/0/12", rsp_valid, rsp_id, rsp_tag); end
   endtask

   task automatic test_random();
      int g;
      logic [3:0] fn [5];
      fn = '{ALU_FUNC_ADD, ALU_FUNC_SUB, ALU_FUNC_AND, ALU_FUNC_OR, ALU_FUNC_XOR};
      do_reset();
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!req_valid[i] || i == last_g) begin
               if ($urandom_range(0, 3) != 0)
                  set_req(i, fn[$urandom_range(0, 4)], $urandom_range(0, 3), $urandom_range(0, 3), TAG_W'($urandom));
               else
                  req_valid[i] = 1'b0;
            end
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 15) == 0);
         #1;
         g = pick();
         checks++; if (req_ready !== onehot(g)) begin errors++; $display("FAIL rnd_grant[%0d]: got %b want %b", c, req_ready, onehot(g)); end
         if (g >= 0) begin
            checks++; if (alu_op_oCont !== req_cont[g] || alu_op1 !== req_op1[g] || alu_op2 !== req_op2[g]) begin errors++; $display("FAIL rnd_alu[%0d]: func=%h op1=%0d op2=%0d from req %0d", c, alu_op_oCont.f_dec.alu_func, alu_op1, alu_op2, g); end
         end else begin
            checks++; if (alu_op_oCont !== nop_instr() || alu_op1 !== 0 || alu_op2 !== 0) begin errors++; $display("FAIL rnd_nop[%0d]: func=%h op1=%0d op2=%0d", c, alu_op_oCont.f_dec.alu_func, alu_op1, alu_op2); end
         end
         step();
         checks++; if (rsp_valid !== m_valid) begin errors++; $display("FAIL rnd_valid[%0d]: got %b want %b", c, rsp_valid, m_valid); end
         if (m_valid) begin
            checks++; if (rsp_id !== ID_W'(m_id) || rsp_tag !== m_tag || rsp_result !== m_res || rsp_zero !== m_zero) begin errors++; $display("FAIL rnd_rsp[%0d]: id=%0d tag=%0d res=%0d z=%b want %0d/%0d/%0d/%b", c, rsp_id, rsp_tag, rsp_result, rsp_zero, m_id, m_tag, m_res, m_zero); end
         end
      end
      flush = 0;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_single_add();
      test_round_robin();
      test_back_pressure();
      test_flush();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_issue_arbiter.md
# alu_issue_arbiter

Shares the single registered `execute` ALU between `NREQ` requesters, for example the main decode path and a branch-compare/address helper. It arbitrates round-robin over valid/ready request channels and drives the winning operation and operands into `execute`. It drives a no-op whenever no operation issues, then returns `execute`'s result to the winner with its requester id and tag. It sits between the decode/issue logic and `execute`, and owns the ALU's operation stream.

## Interface
Parameters:
- `NREQ`, default 2: number of requesters, 2..8.
- `TAG_W`, default 4: width of the opaque tag carried from request to response.
- `ID_W`, default `$clog2(NREQ)`: width of the requester id.

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset; all state is cleared while low.
- `req_valid`  in  NREQ  request i presents an operation.
- `req_ready`  out  NREQ  one-hot grant; request i is accepted this cycle.
- `req_cont`  in  NREQ x `instr_structure`  decoded control per requester.
- `req_op1`, `req_op2`  in  NREQ x 32  operands per requester.
- `req_tag`  in  NREQ x TAG_W  tag per requester.
- `alu_op_oCont`  out  `instr_structure`  operation to `execute`.
- `alu_op1`, `alu_op2`  out  32  operands to `execute`.
- `exe_result`  in  64  `execute` result register.
- `exe_zero`  in  1  `execute` zero flag.
- `flush`  in  1  synchronous kill of the in-flight response; no issue this cycle.
- `rsp_valid`  out  1  a response is presented.
- `rsp_ready`  in  1  the consumer accepts the response.
- `rsp_id`  out  ID_W  requester that owns the response.
- `rsp_tag`  out  TAG_W  tag of the response.
- `rsp_result`  out  64  equals `exe_result`.
- `rsp_zero`  out  1  equals `exe_zero`.

## Operation
- **Slot availability:** an issue slot is free in a cycle when `!rsp_valid || rsp_ready` and `flush` is low.
- **Arbitration:** when the slot is free, the rotating-priority arbiter picks one asserted `req_valid`. It searches upward from the pointer `ptr`, wrapping modulo NREQ.
- **Issue:** the pick sets exactly one `req_ready` bit (the grant). Its `req_cont`, `req_op1` and `req_op2` drive the ALU outputs combinationally in the same cycle.
- **No-op:** when there is no grant, `alu_op_oCont.f_dec.alu_func` is `ALU_FUNC_NOP`. `execute` then holds its result, so `rsp_result` stays stable during back-pressure. All other fields are zero and the operands are zero.
- **Pointer update:** after a grant to requester i, `ptr` becomes (i+1) mod NREQ. With no grant, `ptr` holds.
- **Response capture:** a grant sets `rsp_valid` at the next edge and registers the winner's id and tag. `rsp_result` and `rsp_zero` are direct feedthroughs of `exe_result` and `exe_zero`.
- **Response retire:**
  - A response retires on `rsp_valid && rsp_ready`.
  - If a new grant occurs in the same cycle, `rsp_valid` stays 1 with the new id and tag.
  - Otherwise `rsp_valid` clears.
- **Back-pressure:** while `rsp_valid && !rsp_ready`, every `req_ready` is 0, the ALU receives the no-op, and id, tag and result hold.
- **Flush:** `flush` clears `rsp_valid` at the next edge regardless of `rsp_ready`, and blocks issue that cycle. `ptr` is unchanged.
- **Requester rule:** a requester holds `req_valid` and its payload stable until its grant. The arbiter's behaviour when this is violated is unspecified; the bench flags it.
- **Reset:** while `reset` is low, `rsp_valid` = 0, id = 0, tag = 0, `ptr` = 0, `req_ready` = 0, and the ALU outputs are the no-op.

## Timing
- **Latency:** grant in cycle t gives `rsp_valid` = 1 with the valid result in cycle t+1.
- **Throughput:** one operation per cycle while `rsp_ready` is high.
- **Fairness:** with k requesters continuously valid and `rsp_ready` high, each is granted at least once in every k cycles.
- **Combinational paths:**
  - `req_ready` and the ALU outputs depend combinationally on `req_valid`, `rsp_valid`, `rsp_ready`, `flush` and `ptr`.
  - There is no combinational path from `exe_result` to `req_ready`.
- **Reset deassertion:** the first grant is possible in the first cycle with `reset` high.
- **Reset during a held response:** the response is lost and nothing is replayed.

## Structure
- Shared package `structures.sv` holds `instr_structure`, the `ALU_FUNC_*` codes and the `OPB_*` codes.
- Add `ALU_FUNC_NOP` to the package as a code distinct from every other code, so `execute` hits its hold branch.
- `ID_W` and the response bundle type belong in the package if other blocks consume them.
- One sub-module, `rr_arbiter`: purely combinational, inputs NREQ valids and `ptr`, outputs a one-hot grant and the winner index. The top level owns `ptr`, the response registers and the muxing.

## Test plan
- **Single request, add:** requester 0 sends `ALU_FUNC_ADD` with op1 = 5, op2 = 7, tag 3, and `rsp_ready` = 1. Expect `req_ready[0]` in cycle t, then in t+1 `rsp_valid` = 1, `rsp_id` = 0, `rsp_tag` = 3, `rsp_result` = 12. `rsp_valid` is 0 in t+2 if there are no further requests.
- **Round-robin:** both requesters are continuously valid for 6 cycles from reset. Expect grants in the order 0,1,0,1,0,1 and six responses carrying matching tags.
- **Back-pressure:** issue `ALU_FUNC_SUB` 9-4, then hold `rsp_ready` = 0 for 3 cycles with both requesters valid.
  - Expect `req_ready` = 0, the no-op on the ALU, and `rsp_result` = 5 stable.
  - On `rsp_ready` = 1, expect the retire and the next grant in the same cycle.
- **Flush:** a response with tag 2 is held unready, then `flush` pulses for one cycle. Expect `rsp_valid` = 0 the next cycle, no grant during the flush cycle, and `ptr` unchanged.
- **Reset mid-operation:** assert `reset` low asynchronously with `rsp_valid` = 1. Expect `rsp_valid` = 0, `req_ready` = 0 and the no-op immediately, then `ptr` = 0, so requester 0 wins first after release.
